// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        COMMIT,
        RESP
    } dmem_state_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM: write-enable, registered read every cycle.
module dmem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage (stall while busy, done pulse).
// Optional DMEM_ERR_EN: flag misaligned/out-of-range accesses via mem_err.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] address,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data,
    output logic          done,
    output logic          stall,
    output logic          mem_err
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    dmem_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          store_q, store_d;
    logic          load_q, load_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req;
    logic          acc_err;
    logic [IW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    assign req = memread | memwrite;

`ifdef DMEM_ERR_EN
    logic err_q, err_d;
    logic addr_err;

    assign addr_err = (address[1:0] != 2'b00) ||
                      (address >= AW'(DEPTH * WORD_BYTES));

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && req) begin
            err_d = addr_err;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign acc_err = err_q;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{address[AW-1:IW+2], address[1:0]};
    assign acc_err          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        store_d = store_q;
        load_d  = load_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = address[IW+1:2];
                    wdata_d = write_data;
                    store_d = memwrite;
                    load_d  = memread & ~memwrite;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? COMMIT : BUSY;
                end
            end
            BUSY: begin
                // Leaving when the decremented count hits 0 gives exactly LATENCY-1 BUSY cycles.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (load_q) begin
                    rdata_d = acc_err ? DMEM_ERR_DATA : ram_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            load_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            load_q  <= load_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM reads continuously; in IDLE it follows the live address so LATENCY=1 loads
    // still have the word on the RAM output by the COMMIT cycle.
    assign ram_addr = (state_q == IDLE) ? address[IW+1:2] : idx_q;
    assign ram_we   = (state_q == COMMIT) && store_q && !acc_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign stall     = ((state_q == IDLE) && req) || (state_q == BUSY) || (state_q == COMMIT);
    assign done      = (state_q == RESP);
    assign mem_err   = acc_err && (state_q == RESP);
    assign read_data = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random load/store traffic
// against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned AW      = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          memread = 1'b0;
    logic          memwrite = 1'b0;
    logic [AW-1:0] address = '0;
    logic [31:0]   write_data = '0;
    logic [31:0]   read_data;
    logic          done;
    logic          stall;
    logic          mem_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rd = '0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .AW      (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .memread    (memread),
        .memwrite   (memwrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .done       (done),
        .stall      (stall),
        .mem_err    (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit addr_faults(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return (a[1:0] != 2'b00) || (a >= DEPTH * 4);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Starts at a negedge with the DUT in IDLE; ends at the negedge of the next IDLE cycle.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit          err;
        int unsigned idx;
        int unsigned stall_cnt;
        bit          seen;
        err  = addr_faults(a);
        idx  = (a / 4) % DEPTH;
        seen = 1'b0;
        if (wr) begin
            if (!err) ref_mem[idx] = d;
        end else if (rd) begin
            ref_rd = err ? 32'hDEADBEEF : ref_mem[idx];
        end

        memread = rd; memwrite = wr; address = a; write_data = d;
        #1;
        check("stall_on_req", {31'b0, stall}, 32'd1);
        check("done_low_idle", {31'b0, done}, 32'd0);
        stall_cnt = 1;
        @(posedge clk);
        #1;
        memread = 1'b0; memwrite = 1'b0;
        address = $urandom; write_data = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("done_cycle", 32'(c), 32'(LATENCY + 1));
                check("stall_in_resp", {31'b0, stall}, 32'd0);
                check("read_data", read_data, ref_rd);
                check("mem_err", {31'b0, mem_err}, {31'b0, err});
                break;
            end
            if (stall) stall_cnt++;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        check("stall_cycles", 32'(stall_cnt), 32'(LATENCY + 1));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned op;

        repeat (2) @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_mem_err", {31'b0, mem_err}, 32'd0);
        reset_n = 1'b1;

        // Reset in BUSY aborts the pending store.
        txn(0, 1, 32'h10, 32'hA5A5_0010);
        memwrite = 1'b1; address = 32'h10; write_data = 32'hBAD0_0010;
        @(posedge clk);
        #1 memwrite = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_stall", {31'b0, stall}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_read_data", read_data, 32'd0);
        ref_rd = '0;
        @(negedge clk);
        reset_n = 1'b1;
        txn(1, 0, 32'h10, 32'h0);

        txn(0, 1, 32'h40, 32'hCAFE_F00D);
        txn(1, 0, 32'h40, 32'h0);

        txn(0, 1, 32'h04, 32'h1111_0004);
        txn(0, 1, 32'h08, 32'h2222_0008);
        txn(1, 0, 32'h04, 32'h0);
        txn(1, 0, 32'h08, 32'h0);

        txn(1, 1, 32'h20, 32'h1234_5678);
        txn(1, 0, 32'h20, 32'h0);

`ifdef DMEM_ERR_EN
        txn(1, 0, 32'h41, 32'h0);
        txn(0, 1, 32'h00, 32'h0000_1111);
        txn(0, 1, 32'h1000, 32'h0000_2222);
        txn(1, 0, 32'h00, 32'h0);
`else
        txn(0, 1, 32'h400, 32'h55);
        txn(1, 0, 32'h000, 32'h0);
`endif

        for (int unsigned w = 0; w < 32; w++) txn(0, 1, w * 4, $urandom);
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 31)) * 4;
            if ($urandom_range(0, 3) == 0) a = a + (32'($urandom_range(1, 3)) << 10);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            op = $urandom_range(0, 4);
            if (op < 2) txn(1, 0, a, $urandom);
            else if (op < 4) txn(0, 1, a, $urandom);
            else txn(1, 1, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the MEM-stage load/store interface. The pipeline's MEM stage is the initiator.
- Accepts one load or store per transaction and completes it after a fixed multi-cycle latency.
- Drives a stall back to the pipeline registers while the access is in flight, then returns load data with a one-cycle done pulse.
- Replaces the single-cycle combinational data memory inside the memory stage.

Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two.
- LATENCY, 3: cycles from request acceptance to the done pulse; legal range 1 to 15.
- AW, 32: byte-address width.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- memread, input, 1: load request from the MEM stage.
- memwrite, input, 1: store request from the MEM stage.
- address, input, AW: byte address (ALU result).
- write_data, input, 32: store data (forwarded rt value).
- read_data, output, 32: load result; valid while done is high, and held afterwards.
- done, output, 1: one-cycle completion pulse.
- stall, output, 1: freezes the PC and all pipeline registers.
- mem_err, output, 1: misaligned or out-of-range access (DMEM_ERR_EN only; otherwise tied to 0).

Behaviour:
- Reset values: state IDLE, read_data 0, done 0, stall 0, mem_err 0, counter 0. Memory array is not reset.
- Reset asserted mid-transaction aborts the access. A store that has not reached its commit cycle is not written.
- Word index is address[log2(DEPTH)+1:2]. Upper address bits beyond the array are ignored (wrap) unless DMEM_ERR_EN is defined.
- FSM state IDLE:
  - req = memread | memwrite. If req is high, latch address, write_data and the operation, load counter = LATENCY-1, and go to BUSY (or to COMMIT if LATENCY=1).
  - If memread and memwrite are both high, the store wins and no load data is returned.
- FSM state BUSY: decrement the counter each cycle; when the counter is 0, go to COMMIT. Inputs are ignored; latched values are used.
- FSM state COMMIT:
  - A store writes the latched word.
  - A load registers mem[index] into read_data.
  - Next state is RESP.
- FSM state RESP: done = 1 for exactly this cycle, then return to IDLE. Requests are not sampled in RESP.
- stall is combinational: stall = (IDLE & req) | BUSY | COMMIT. It is 0 in RESP, so the pipeline advances on the RESP edge and the next instruction is seen in IDLE.
- Latency: the request is seen in IDLE at cycle t; done is high at t+LATENCY+1. stall is high for exactly LATENCY+1 cycles.
- Back-to-back requests: two consecutive memory instructions each incur the full LATENCY+1 stall. There is no pipelining across transactions.
- read_data holds its value until the next load commits; stores do not change it.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - An access with address[1:0] != 0, or with address >= DEPTH*4, sets mem_err = 1 during RESP.
  - The store is suppressed, and a faulting load returns 32'hDEADBEEF.
- Undefined: mem_err is tied to 0, the low two bits are ignored, and upper bits wrap.

Decomposition:
- Shared package mips_pkg holds:
  - the state encoding typedef (IDLE, BUSY, COMMIT, RESP);
  - the constant WORD_BYTES=4;
  - the error data constant 32'hDEADBEEF.
- One natural sub-module, dmem_array: single-port synchronous word RAM (DEPTH x 32, write enable, registered read). The FSM and latency counter stay in dmem_responder.

Test Plan:
- Reset: reset_n low for 2 cycles, then pulse reset_n low while in BUSY → stall, done and read_data are 0 immediately; the aborted store to 0x10 leaves the word unchanged.
- Store then load, LATENCY=3: store 0xCAFEF00D to 0x40 → stall high 4 cycles, done at t+4. Then load 0x40 → read_data 0xCAFEF00D with done at t+4.
- Back-to-back: load 0x04 followed immediately by load 0x08 → two separate 4-cycle stalls, two done pulses, correct data each time, no request lost.
- Simultaneous memread and memwrite to 0x20 with data 0x12345678 → the store commits; read_data keeps its previous value.
- Wrap, with DMEM_ERR_EN undefined and DEPTH=256: store 0x55 to 0x400 → aliases address 0x000, and a load from 0x000 returns 0x55.
- DMEM_ERR_EN defined: load from 0x41 → mem_err = 1 and read_data 0xDEADBEEF at done. A store to 0x1000 → mem_err = 1 and memory is unchanged.
